// File: rtl/routed_fifos_pkg.sv
// rtl/routed_fifos_pkg.sv - width helpers, default constants and typedefs for routed_fifos
package routed_fifos_pkg;

  localparam int DEF_NUM_REQS = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_DEPTH    = 4;
  localparam int DEF_DCWID    = 8;

  // Destination index width; a single channel still needs one bit of index
  function automatic int didx_w(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  // Occupancy width: one extra bit so that a full FIFO is distinguishable from an empty one
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [didx_w(DEF_NUM_REQS)-1:0] dest_t;
  typedef logic [cnt_w(DEF_DEPTH)-1:0]     count_t;

endpackage

// File: rtl/count_fifo.sv
// rtl/count_fifo.sv - first-word-fall-through FIFO with occupancy count
module count_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CWID  = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic             empty,
  output logic             full,
  output logic [CWID-1:0]  count,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CWID-1:0]  wr_ptr;
  logic [CWID-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit: equal means empty, wrap bits differing with equal low bits means full
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // A full FIFO refuses a push even when popped that cycle; an empty one ignores pop
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage write; contents need no reset because the pointers qualify them
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  // Pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/routed_fifos.sv
// rtl/routed_fifos.sv - demultiplex one packet stream into per-destination FIFOs
module routed_fifos
  import routed_fifos_pkg::*;
#(
  parameter  int NUM_REQS = DEF_NUM_REQS,
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int DCWID    = DEF_DCWID,
  localparam int DIDX     = didx_w(NUM_REQS),
  localparam int CWID     = cnt_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [DIDX-1:0]          in_dest,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic [NUM_REQS-1:0]      pop,
  output logic [NUM_REQS-1:0]      empty,
  output logic [NUM_REQS-1:0]      full,
  output logic [NUM_REQS*WIDTH-1:0] flat_data_out,
  output logic [NUM_REQS*CWID-1:0] flat_count,
  output logic [DCWID-1:0]         drop_cnt,
  output logic                     err
);

  localparam logic [DIDX:0] NREQ = (DIDX+1)'(NUM_REQS);

  logic [1:0]           rst_sync;
  logic                 rst_int;
  logic                 dest_ok;
  logic                 xfer;
  logic [2**DIDX-1:0]   full_pad;
  logic [NUM_REQS-1:0]  push;

  // Reset asserts immediately and releases two clocks later, in step with clk
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int = rst_sync[1];

  // Widen full to cover every encodable index so an out-of-range dest never indexes past it
  always_comb begin
    full_pad = '0;
    for (int i = 0; i < NUM_REQS; i++) full_pad[i] = full[i];
  end

  // Out-of-range destinations are always accepted so they can be dropped
  assign dest_ok  = ({1'b0, in_dest} < NREQ);
  assign in_ready = rst_int & (dest_ok ? ~full_pad[in_dest] : 1'b1);
  assign xfer     = in_valid & in_ready;

  // One-hot push toward the addressed channel
  always_comb begin
    push = '0;
    for (int i = 0; i < NUM_REQS; i++) push[i] = xfer & dest_ok & (in_dest == DIDX'(i));
  end

  // Saturating drop counter and sticky error for out-of-range destinations
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      drop_cnt <= '0;
      err      <= 1'b0;
    end else if (xfer && !dest_ok) begin
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      err <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REQS; i++) begin : g_ch
    count_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst_int),
      .push     (push[i]),
      .pop      (pop[i]),
      .data_in  (in_data),
      .empty    (empty[i]),
      .full     (full[i]),
      .count    (flat_count[i*CWID +: CWID]),
      .data_out (flat_data_out[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_routed_fifos.sv
// tb/tb_routed_fifos.sv - directed-vector bench for routed_fifos
module tb_routed_fifos;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        a_valid = 1'b0;
  logic [1:0]  a_dest  = '0;
  logic [7:0]  a_data  = '0;
  logic        a_ready;
  logic [3:0]  a_pop   = '0;
  logic [3:0]  a_empty;
  logic [3:0]  a_full;
  logic [31:0] a_fdata;
  logic [11:0] a_fcnt;
  logic [7:0]  a_drop;
  logic        a_err;

  logic        b_valid = 1'b0;
  logic [1:0]  b_dest  = '0;
  logic [7:0]  b_data  = '0;
  logic        b_ready;
  logic [2:0]  b_pop   = '0;
  logic [2:0]  b_empty;
  logic [2:0]  b_full;
  logic [23:0] b_fdata;
  logic [8:0]  b_fcnt;
  logic [7:0]  b_drop;
  logic        b_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  routed_fifos #(.NUM_REQS(4), .WIDTH(8), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_dest(a_dest), .in_data(a_data),
    .in_ready(a_ready), .pop(a_pop), .empty(a_empty), .full(a_full),
    .flat_data_out(a_fdata), .flat_count(a_fcnt), .drop_cnt(a_drop), .err(a_err)
  );

  routed_fifos #(.NUM_REQS(3), .WIDTH(8), .DEPTH(4)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_dest(b_dest), .in_data(b_data),
    .in_ready(b_ready), .pop(b_pop), .empty(b_empty), .full(b_full),
    .flat_data_out(b_fdata), .flat_count(b_fcnt), .drop_cnt(b_drop), .err(b_err)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] head4(input int ch);
    return a_fdata[ch*8 +: 8];
  endfunction

  function automatic logic [2:0] cnt4(input int ch);
    return a_fcnt[ch*3 +: 3];
  endfunction

  initial begin
    tick();
    tick();
    check_vec("rst_empty", 32'(a_empty), 32'hF);
    check_vec("rst_full", 32'(a_full), 32'h0);
    check_vec("rst_count", 32'(a_fcnt), 32'h0);
    check_vec("rst_data", a_fdata, 32'h0);
    check_vec("rst_drop", 32'(a_drop), 32'h0);
    check_vec("rst_err", 32'(a_err), 32'h0);
    check_vec("rst_empty3", 32'(b_empty), 32'h7);

    rst = 1'b1;
    tick(); tick(); tick();
    check_vec("ready_idle", 32'(a_ready), 32'h1);

    // single push to channel 2
    a_valid = 1'b1; a_dest = 2'd2; a_data = 8'hA1;
    tick();
    a_valid = 1'b0;
    check_vec("p1_empty", 32'(a_empty), 32'hB);
    check_vec("p1_head2", 32'(head4(2)), 32'hA1);
    check_vec("p1_cnt2", 32'(cnt4(2)), 32'h1);

    // five pushes to channel 1, fifth refused
    for (int k = 0; k < 5; k++) begin
      a_valid = 1'b1; a_dest = 2'd1; a_data = 8'(8'h10 + k);
      #1;
      check_vec($sformatf("fill_ready%0d", k), 32'(a_ready), (k < 4) ? 32'h1 : 32'h0);
      tick();
    end
    a_valid = 1'b0;
    check_vec("fill_full", 32'(a_full), 32'h2);
    check_vec("fill_cnt1", 32'(cnt4(1)), 32'h4);
    check_vec("fill_head1", 32'(head4(1)), 32'h10);

    // full channel: push and pop together, push must be refused
    a_valid = 1'b1; a_dest = 2'd1; a_data = 8'h55; a_pop = 4'b0010;
    #1;
    check_vec("fullpp_ready", 32'(a_ready), 32'h0);
    tick();
    a_valid = 1'b0;
    check_vec("fullpp_cnt1", 32'(cnt4(1)), 32'h3);
    check_vec("fullpp_head1", 32'(head4(1)), 32'h11);
    tick();
    check_vec("drain_head1a", 32'(head4(1)), 32'h12);
    tick();
    check_vec("drain_head1b", 32'(head4(1)), 32'h13);
    tick();
    check_vec("drain_empty", 32'(a_empty), 32'hB);
    tick();
    a_pop = 4'b0000;
    check_vec("underflow_cnt1", 32'(cnt4(1)), 32'h0);

    // empty channel 0: push and pop in the same cycle
    a_valid = 1'b1; a_dest = 2'd0; a_data = 8'h77; a_pop = 4'b0001;
    tick();
    a_valid = 1'b0; a_pop = 4'b0000;
    check_vec("epp_cnt0", 32'(cnt4(0)), 32'h1);
    check_vec("epp_head0", 32'(head4(0)), 32'h77);

    // out-of-range destination on the three-channel instance
    b_valid = 1'b1; b_dest = 2'd3; b_data = 8'hEE;
    #1;
    check_vec("drop_ready", 32'(b_ready), 32'h1);
    tick();
    check_vec("drop_cnt1", 32'(b_drop), 32'h1);
    check_vec("drop_err", 32'(b_err), 32'h1);
    check_vec("drop_empty", 32'(b_empty), 32'h7);
    check_vec("drop_count", 32'(b_fcnt), 32'h0);
    for (int k = 0; k < 299; k++) tick();
    b_valid = 1'b0;
    check_vec("drop_sat", 32'(b_drop), 32'hFF);

    // mid-stream reset with channels partly filled
    a_valid = 1'b1; a_dest = 2'd3; a_data = 8'h33;
    tick();
    a_valid = 1'b0;
    check_vec("pre_rst_empty", 32'(a_empty), 32'h2);
    rst = 1'b0;
    #2;
    check_vec("mid_rst_empty", 32'(a_empty), 32'hF);
    check_vec("mid_rst_count", 32'(a_fcnt), 32'h0);
    check_vec("mid_rst_err", 32'(b_err), 32'h0);
    check_vec("mid_rst_drop", 32'(b_drop), 32'h0);
    tick();
    rst = 1'b1;
    tick(); tick(); tick();
    a_valid = 1'b1; a_dest = 2'd3; a_data = 8'h99;
    tick();
    a_valid = 1'b0;
    check_vec("post_rst_head3", 32'(head4(3)), 32'h99);
    check_vec("post_rst_cnt3", 32'(cnt4(3)), 32'h1);
    check_vec("post_rst_empty", 32'(a_empty), 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
